// File: rtl/scanner_pkg.sv
// Shared definitions for the scanner link transmitter.
//   state_e     : top-level FSM state encoding (also driven onto stateOut)
//   CMD_*       : status / frame command codes sent as serial words
//   PEER_*      : codes accepted on localTransferInput
package scanner_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StActive   = 3'd1,
      StStandby  = 3'd2,
      StTransfer = 3'd3,
      StDrain    = 3'd4
   } state_e;

   localparam logic [2:0] CMD_READY = 3'd2;
   localparam logic [2:0] CMD_START = 3'd3;
   localparam logic [2:0] CMD_FULL  = 3'd4;
   localparam logic [2:0] CMD_DATA  = 3'd7;

   localparam logic [1:0] PEER_START = 2'b01;
   localparam logic [1:0] PEER_HALF  = 2'b10;

endpackage

// File: rtl/scanner_link_tx_if.sv
// Peer / link signal bundle of the scanner link transmitter.
//   localTransferInput : peer code into the transmitter
//   readyForTransferIn : level-sensitive link grant
//   clkOut, dataOut    : two-wire serial link
//   busy               : a word is shifting
//   fillLevel          : current buffer fill
//   stateOut           : FSM state encoding
// master = environment side, slave = transmitter side.
interface scanner_link_tx_if #(
   parameter int unsigned DEPTH = 10
) ();
   localparam int unsigned FILL_W = $clog2(DEPTH + 1);

   logic [1:0]        localTransferInput;
   logic              readyForTransferIn;
   logic              clkOut;
   logic              dataOut;
   logic              busy;
   logic [FILL_W-1:0] fillLevel;
   logic [2:0]        stateOut;

   modport master (
      output localTransferInput, readyForTransferIn,
      input  clkOut, dataOut, busy, fillLevel, stateOut
   );

   modport slave (
      input  localTransferInput, readyForTransferIn,
      output clkOut, dataOut, busy, fillLevel, stateOut
   );
endinterface

// File: rtl/serial_word_tx.sv
// One-word MSB-first serialiser for the two-wire link.
//   i_load / i_word : accept a word when free (idle, or in the final cycle of a word)
//   o_busy          : high from the cycle after load until the last high half ends
//   o_done          : high during the final cycle of a word; reloading then gives no gap
//   o_clk_out       : registered bit clock, low BIT_HALF cycles then high BIT_HALF cycles
//   o_data_out      : bit value, stable across the whole bit; 0 when idle
module serial_word_tx #(
   parameter int unsigned WORD_W   = 8,
   parameter int unsigned BIT_HALF = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_word,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_clk_out,
   output logic              o_data_out
);
   localparam int unsigned HALF_W = (BIT_HALF > 1) ? $clog2(BIT_HALF) : 1;
   localparam int unsigned BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   logic              r_busy;
   logic              r_clk;
   logic [WORD_W-1:0] r_shift;
   logic [HALF_W-1:0] r_half;
   logic [BIT_W-1:0]  r_bit;

   logic w_half_end;
   logic w_last_bit;
   logic w_done;
   logic w_free;

   assign w_half_end = (r_half == HALF_W'(BIT_HALF - 1));
   assign w_last_bit = (r_bit == BIT_W'(WORD_W - 1));
   assign w_done     = r_busy && r_clk && w_half_end && w_last_bit;
   assign w_free     = !r_busy || w_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy  <= 1'b0;
         r_clk   <= 1'b0;
         r_shift <= '0;
         r_half  <= '0;
         r_bit   <= '0;
      end else if (i_load && w_free) begin
         r_busy  <= 1'b1;
         r_clk   <= 1'b0;
         r_shift <= i_word;
         r_half  <= '0;
         r_bit   <= '0;
      end else if (r_busy) begin
         if (!w_half_end) begin
            r_half <= r_half + HALF_W'(1);
         end else begin
            r_half <= '0;
            if (!r_clk) begin
               r_clk <= 1'b1;
            end else if (w_last_bit) begin
               // Clearing the shifter also returns dataOut to 0 when idle.
               r_busy  <= 1'b0;
               r_clk   <= 1'b0;
               r_shift <= '0;
            end else begin
               r_clk   <= 1'b0;
               r_bit   <= r_bit + BIT_W'(1);
               r_shift <= r_shift << 1;
            end
         end
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = w_done;
   assign o_clk_out  = r_clk;
   assign o_data_out = r_shift[WORD_W-1];
endmodule

// File: rtl/scanner_link_tx.sv
// Scanner link transmitter: simulated scan-buffer fill, one-shot threshold commands
// and a framed data transfer (CMD_DATA, count, payload 0..fill-1) on a two-wire link.
//   clk, rst : system clock, asynchronous active-high reset
//   link     : peer code / grant in, clkOut / dataOut / busy / fillLevel / stateOut out
module scanner_link_tx
   import scanner_pkg::*;
#(
   parameter int unsigned WORD_W     = 8,
   parameter int unsigned DEPTH      = 10,
   parameter int unsigned SAMPLE_DIV = 8,
   parameter int unsigned TH_READY   = 8,
   parameter int unsigned TH_START   = 9,
   parameter int unsigned BIT_HALF   = 1
) (
   input  logic               clk,
   input  logic               rst,
   scanner_link_tx_if.slave   link
);
   localparam int unsigned FILL_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W  = FILL_W + 1;
   localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);

   state_e            r_state;
   logic [FILL_W-1:0] r_fill;
   logic [DIV_W-1:0]  r_div;
   logic              r_sent_ready, r_sent_start, r_sent_full;
   logic [IDX_W-1:0]  r_idx;          // next frame word: 0 header, 1 count, 2.. payload
   logic [2:0]        r_q [0:2];
   logic [1:0]        r_q_cnt;

   logic              w_ser_busy, w_ser_done, w_ser_free;
   logic              w_fill_inc;
   logic [FILL_W-1:0] w_fill_nxt;
   logic              w_push_ready, w_push_start, w_push_full, w_push;
   logic [2:0]        w_push_cmd;
   logic              w_pop_cmd, w_frame_load, w_load;
   logic [IDX_W-1:0]  w_last_idx;
   logic [WORD_W-1:0] w_word;
   logic              w_peer_half;

   assign w_ser_free  = !w_ser_busy || w_ser_done;
   assign w_peer_half = (link.localTransferInput == PEER_HALF);
   assign w_fill_nxt  = r_fill + FILL_W'(1);
   assign w_fill_inc  = (r_state == StActive) && (r_div == DIV_W'(SAMPLE_DIV - 1))
                        && (r_fill < FILL_W'(DEPTH));

   assign w_push_ready = w_fill_inc && (w_fill_nxt == FILL_W'(TH_READY)) && !r_sent_ready;
   assign w_push_start = w_fill_inc && (w_fill_nxt == FILL_W'(TH_START)) && !r_sent_start;
   assign w_push_full  = w_fill_inc && (w_fill_nxt == FILL_W'(DEPTH)) && !r_sent_full;
   assign w_push       = w_push_ready || w_push_start || w_push_full;

   always_comb begin
      w_push_cmd = CMD_READY;
      if (w_push_start)     w_push_cmd = CMD_START;
      else if (w_push_full) w_push_cmd = CMD_FULL;
   end

   // Queued commands always win the serialiser, so they precede the frame header.
   assign w_pop_cmd    = (r_q_cnt != 2'd0) && w_ser_free && (r_state != StDrain);
   assign w_last_idx   = IDX_W'(r_fill) + IDX_W'(1);
   assign w_frame_load = (r_state == StTransfer) && !w_pop_cmd && w_ser_free
                         && (r_idx <= w_last_idx) && !w_peer_half;
   assign w_load       = w_pop_cmd || w_frame_load;

   always_comb begin
      w_word = '0;
      if (w_pop_cmd)                 w_word = WORD_W'(r_q[0]);
      else if (r_idx == '0)          w_word = WORD_W'(CMD_DATA);
      else if (r_idx == IDX_W'(1))   w_word = WORD_W'(r_fill);
      else                           w_word = WORD_W'(r_idx - IDX_W'(2));
   end

   // Three-entry FIFO; head at r_q[0]. Each command is pushed once per session,
   // so the queue cannot overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q_cnt <= 2'd0;
         for (int i = 0; i < 3; i++) r_q[i] <= 3'd0;
      end else begin
         if (w_pop_cmd) begin
            r_q[0] <= r_q[1];
            r_q[1] <= r_q[2];
         end
         if (w_push && w_pop_cmd) begin
            r_q[r_q_cnt - 2'd1] <= w_push_cmd;
         end else if (w_push && (r_q_cnt < 2'd3)) begin
            r_q[r_q_cnt] <= w_push_cmd;
            r_q_cnt      <= r_q_cnt + 2'd1;
         end else if (w_pop_cmd) begin
            r_q_cnt <= r_q_cnt - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StIdle;
         r_fill       <= '0;
         r_div        <= '0;
         r_sent_ready <= 1'b0;
         r_sent_start <= 1'b0;
         r_sent_full  <= 1'b0;
         r_idx        <= '0;
      end else begin
         if (w_push_ready) r_sent_ready <= 1'b1;
         if (w_push_start) r_sent_start <= 1'b1;
         if (w_push_full)  r_sent_full  <= 1'b1;
         unique case (r_state)
            StIdle: begin
               r_fill       <= '0;
               r_div        <= '0;
               r_idx        <= '0;
               r_sent_ready <= 1'b0;
               r_sent_start <= 1'b0;
               r_sent_full  <= 1'b0;
               if (link.localTransferInput == PEER_START) r_state <= StActive;
            end
            StActive: begin
               r_div <= (r_div == DIV_W'(SAMPLE_DIV - 1)) ? '0 : r_div + DIV_W'(1);
               if (w_fill_inc) r_fill <= w_fill_nxt;
               if ((r_fill == FILL_W'(DEPTH)) && (r_q_cnt == 2'd0)) begin
                  r_idx   <= '0;
                  r_state <= link.readyForTransferIn ? StTransfer : StStandby;
               end
            end
            StStandby: begin
               if (link.readyForTransferIn || w_peer_half) begin
                  r_idx   <= '0;
                  r_state <= StTransfer;
               end
            end
            StTransfer: begin
               if (w_peer_half) begin
                  r_state <= StDrain;
               end else if (w_frame_load) begin
                  r_idx <= r_idx + IDX_W'(1);
               end else if ((r_idx > w_last_idx) && w_ser_done) begin
                  r_fill  <= '0;
                  r_state <= StIdle;
               end
            end
            StDrain: begin
               if (!w_ser_busy) begin
                  r_fill  <= '0;
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   serial_word_tx #(
      .WORD_W   (WORD_W),
      .BIT_HALF (BIT_HALF)
   ) u_ser (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_word     (w_word),
      .o_busy     (w_ser_busy),
      .o_done     (w_ser_done),
      .o_clk_out  (link.clkOut),
      .o_data_out (link.dataOut)
   );

   assign link.busy      = w_ser_busy;
   assign link.fillLevel = r_fill;
   assign link.stateOut  = r_state;
endmodule

// File: tb/tb_scanner_link_tx.sv
// Randomised bench for scanner_link_tx: a default instance (A) and a wide/slow
// instance (B). Serial words are rebuilt from the link wires and compared with
// word lists built from the frame rules.
module tb_scanner_link_tx;
   localparam int A_W = 8,  A_D = 10, A_DIV = 8, A_HALF = 1;
   localparam int B_W = 16, B_D = 20, B_HALF = 3;
   localparam int A_WORD_CYC = 2 * A_HALF * A_W;
   localparam int B_WORD_CYC = 2 * B_HALF * B_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   scanner_link_tx_if #(.DEPTH(A_D)) if_a ();
   scanner_link_tx_if #(.DEPTH(B_D)) if_b ();

   scanner_link_tx #(
      .WORD_W(A_W), .DEPTH(A_D), .SAMPLE_DIV(A_DIV), .TH_READY(8), .TH_START(9),
      .BIT_HALF(A_HALF)
   ) u_dut_a (
      .clk  (clk),
      .rst  (rst),
      .link (if_a.slave)
   );

   scanner_link_tx #(
      .WORD_W(B_W), .DEPTH(B_D), .SAMPLE_DIV(8), .TH_READY(16), .TH_START(18),
      .BIT_HALF(B_HALF)
   ) u_dut_b (
      .clk  (clk),
      .rst  (rst),
      .link (if_b.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Link monitors: a word is the WORD_W bits seen on clkOut rising edges, MSB first.
   int unsigned a_words[$], a_starts[$], a_fill_iv[$];
   int unsigned b_words[$], b_starts[$];
   logic a_clk_prev, b_clk_prev;
   int a_bits, b_bits, a_fill_prev;
   int unsigned a_fill_t;
   logic [31:0] a_sh, b_sh;

   always @(negedge clk) begin : mon_a
      logic [31:0] nsh;
      if (rst) begin
         a_clk_prev  <= 1'b0;
         a_bits      <= 0;
         a_sh        <= '0;
         a_fill_prev <= 0;
      end else begin
         a_clk_prev <= if_a.clkOut;
         if (if_a.clkOut && !a_clk_prev) begin
            nsh = {a_sh[30:0], if_a.dataOut};
            if (a_bits == 0) a_starts.push_back(cyc);
            if (a_bits == A_W - 1) begin
               a_words.push_back(nsh);
               a_sh   <= '0;
               a_bits <= 0;
            end else begin
               a_sh   <= nsh;
               a_bits <= a_bits + 1;
            end
         end
         if (int'(if_a.fillLevel) == a_fill_prev + 1) begin
            if (a_fill_prev >= 1) a_fill_iv.push_back(cyc - a_fill_t);
            a_fill_t <= cyc;
         end
         a_fill_prev <= int'(if_a.fillLevel);
      end
   end

   always @(negedge clk) begin : mon_b
      logic [31:0] nsh;
      if (rst) begin
         b_clk_prev <= 1'b0;
         b_bits     <= 0;
         b_sh       <= '0;
      end else begin
         b_clk_prev <= if_b.clkOut;
         if (if_b.clkOut && !b_clk_prev) begin
            nsh = {b_sh[30:0], if_b.dataOut};
            if (b_bits == 0) b_starts.push_back(cyc);
            if (b_bits == B_W - 1) begin
               b_words.push_back(nsh);
               b_sh   <= '0;
               b_bits <= 0;
            end else begin
               b_sh   <= nsh;
               b_bits <= b_bits + 1;
            end
         end
      end
   end

   // Bench actions happen 1 ns after the falling edge, after monitor updates.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_state_a(input int s, input int limit);
      int n = 0;
      while (int'(if_a.stateOut) != s && n < limit) begin
         tick();
         n++;
      end
      check_eq($sformatf("wait_state_a_%0d", s), if_a.stateOut, s);
   endtask

   // mode 0: grant from STANDBY, 1: peer-half from STANDBY,
   // 2: grant held from the start, 3: grant then abort during payload word k
   task automatic run_session_a(input int mode, input int k);
      int unsigned exp[$];
      int base, sbase, fbase, bad, n, last;
      base  = a_words.size();
      sbase = a_starts.size();
      fbase = a_fill_iv.size();
      exp = '{2, 3, 4, 7, A_D};
      last = (mode == 3) ? k : A_D - 1;
      for (int p = 0; p <= last; p++) exp.push_back(p % (1 << A_W));

      if_a.readyForTransferIn = (mode == 2);
      if_a.localTransferInput = 2'b01;
      tick();
      if_a.localTransferInput = 2'b00;
      check_eq("enter_active", if_a.stateOut, 1);

      if (mode != 2) begin
         wait_state_a(2, 400);
         repeat (30 + $urandom_range(0, 20)) tick();
         check_eq("standby_fill", if_a.fillLevel, A_D);
         check_eq("standby_cmds", a_words.size() - base, 3);
         if (mode == 0) begin
            if_a.localTransferInput = 2'b01;
            tick();
            if_a.localTransferInput = 2'b00;
            check_eq("start_ignored", if_a.stateOut, 2);
         end
         if (mode == 1) begin
            if_a.localTransferInput = 2'b10;
            tick();
            if_a.localTransferInput = 2'b00;
         end else begin
            if_a.readyForTransferIn = 1'b1;
            tick();
         end
         check_eq("enter_transfer", if_a.stateOut, 3);
      end

      if (mode == 3) begin
         n = 0;
         while (!(a_words.size() == base + 5 + k && a_bits > 0) && n < 1000) begin
            tick();
            n++;
         end
         check_eq("abort_point", a_words.size() - base, 5 + k);
         if_a.localTransferInput = 2'b10;
         tick();
         if_a.localTransferInput = 2'b00;
         if_a.readyForTransferIn = 1'b0;
         check_eq("enter_drain", if_a.stateOut, 4);
      end

      wait_state_a(0, 3000);
      if_a.readyForTransferIn = 1'b0;
      check_eq("idle_fill", if_a.fillLevel, 0);
      repeat (40) tick();
      check_eq("no_partial_word", a_bits, 0);
      check_eq("n_words", a_words.size() - base, exp.size());
      for (int j = 0; j < exp.size() && base + j < a_words.size(); j++)
         check_eq($sformatf("m%0d_word%0d", mode, j), a_words[base + j], exp[j]);
      bad = 0;
      for (int j = sbase + 4; j < a_starts.size(); j++)
         if (a_starts[j] - a_starts[j - 1] != A_WORD_CYC) bad++;
      check_eq("frame_gap_bad", bad, 0);
      bad = 0;
      for (int j = fbase; j < a_fill_iv.size(); j++)
         if (a_fill_iv[j] != A_DIV) bad++;
      check_eq("fill_iv_count", a_fill_iv.size() - fbase, A_D - 1);
      check_eq("fill_iv_bad", bad, 0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin : stim
      int n, bad, mode;
      if_a.localTransferInput = 2'b00;
      if_a.readyForTransferIn = 1'b0;
      if_b.localTransferInput = 2'b00;
      if_b.readyForTransferIn = 1'b0;
      tick();
      check_eq("rst_clk", if_a.clkOut, 0);
      check_eq("rst_data", if_a.dataOut, 0);
      check_eq("rst_busy", if_a.busy, 0);
      check_eq("rst_fill", if_a.fillLevel, 0);
      check_eq("rst_state", if_a.stateOut, 0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check_eq("idle_hold", if_a.stateOut, 0);

      for (int i = 0; i < 7; i++) begin
         mode = (i < 4) ? i : int'($urandom_range(0, 3));
         run_session_a(mode, (i == 3) ? 2 : int'($urandom_range(0, A_D - 1)));
      end

      // Wide instance: count word and word length.
      if_b.readyForTransferIn = 1'b1;
      if_b.localTransferInput = 2'b01;
      tick();
      if_b.localTransferInput = 2'b00;
      n = 0;
      while (b_words.size() < 5 && n < 3000) begin
         tick();
         n++;
      end
      check_eq("b_first_words", b_words.size() >= 5, 1);
      if (b_words.size() >= 5) begin
         check_eq("b_cmd_ready", b_words[0], 2);
         check_eq("b_cmd_start", b_words[1], 3);
         check_eq("b_cmd_full", b_words[2], 4);
         check_eq("b_header", b_words[3], 7);
         check_eq("b_count", b_words[4], B_D);
         check_eq("b_word_cyc", b_starts[4] - b_starts[3], B_WORD_CYC);
      end
      n = 0;
      while (int'(if_b.stateOut) != 0 && n < 5000) begin
         tick();
         n++;
      end
      check_eq("b_idle", if_b.stateOut, 0);
      if_b.readyForTransferIn = 1'b0;
      repeat (10) tick();
      check_eq("b_n_words", b_words.size(), 5 + B_D);
      bad = 0;
      for (int j = 5; j < b_words.size(); j++)
         if (b_words[j] != j - 5) bad++;
      check_eq("b_payload_bad", bad, 0);

      // Asynchronous reset in the middle of a word while clkOut is high.
      if_a.localTransferInput = 2'b01;
      tick();
      if_a.localTransferInput = 2'b00;
      wait_state_a(2, 400);
      if_a.readyForTransferIn = 1'b1;
      n = 0;
      while (!(if_a.clkOut && a_bits >= 2 && int'(if_a.stateOut) == 3) && n < 500) begin
         tick();
         n++;
      end
      check_eq("pre_reset_clk", if_a.clkOut, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("async_clk", if_a.clkOut, 0);
      check_eq("async_data", if_a.dataOut, 0);
      check_eq("async_busy", if_a.busy, 0);
      check_eq("async_fill", if_a.fillLevel, 0);
      check_eq("async_state", if_a.stateOut, 0);
      if_a.readyForTransferIn = 1'b0;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check_eq("post_reset_state", if_a.stateOut, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/scanner_link_tx.md
Name: scanner_link_tx

Overview:
- Parametrised successor to the single-channel scanner controller.
- Simulates a scan buffer that fills at a fixed sample rate.
- Emits one-shot status commands at configurable fill thresholds.
- When permitted, serialises a framed data transfer (header, count, payload) on a two-wire link (clkOut/dataOut) to the peer scanner / output driver.

Parameters:
- WORD_W, 8, width of every serial word (command, count, payload), sent MSB first.
- DEPTH, 10, buffer capacity in samples; fill counter width is $clog2(DEPTH+1).
- SAMPLE_DIV, 8, clk cycles per simulated sample while ACTIVE (>=2).
- TH_READY, 8, fill level that triggers CMD_READY (80%).
- TH_START, 9, fill level that triggers CMD_START (90%); requires TH_READY < TH_START < DEPTH.
- BIT_HALF, 1, clk cycles per clkOut half-period (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- localTransferInput  in  2  peer code: 01 = start scanning, 10 = peer buffer at 50%, others ignored
- readyForTransferIn  in  1  link grant from output driver, level-sensitive
- clkOut  out  1  serial bit clock; data valid on rising edge
- dataOut  out  1  serial data
- busy  out  1  high while a word is shifting
- fillLevel  out  $clog2(DEPTH+1)  current buffer fill
- stateOut  out  3  current FSM state encoding

Behaviour:
- Reset (async, rst=1):
  - state IDLE, fill 0, all sent-flags cleared, sample divider 0.
  - clkOut=0, dataOut=0, busy=0.
  - Reset mid-frame aborts immediately with no partial word completion.
- States: IDLE=0, ACTIVE=1, STANDBY=2, TRANSFER=3, DRAIN=4.
- IDLE:
  - localTransferInput==01 -> ACTIVE.
  - Fill cleared and sent-flags cleared on entry.
- ACTIVE:
  - Divider counts 0..SAMPLE_DIV-1.
  - On wrap, fill increments if fill<DEPTH; the fill never exceeds DEPTH.
  - Thresholds:
    - fill reaches TH_READY -> queue CMD_READY=2 once.
    - fill reaches TH_START -> queue CMD_START=3 once.
    - fill reaches DEPTH -> queue CMD_FULL=4 once.
  - At fill==DEPTH and the queue empty: readyForTransferIn=1 -> TRANSFER, else -> STANDBY.
- Command queue:
  - Depth 3, FIFO order.
  - A command crossing while a word is shifting waits; it is never dropped and never duplicated.
- STANDBY:
  - Any of the following -> TRANSFER: readyForTransferIn=1, or localTransferInput==10.
  - Otherwise hold. Fill is frozen.
- TRANSFER:
  - Frame = CMD_DATA=7, then count word = fill (zero-extended to WORD_W), then fill payload words with values 0,1,...,fill-1 (mod 2^WORD_W).
  - localTransferInput==10 during TRANSFER -> DRAIN: finish the current word, drop the rest of the frame, go to IDLE.
  - Frame completion -> IDLE.
- DRAIN:
  - Waits for busy=0, then -> IDLE.
- Serialiser:
  - Each bit: dataOut set while clkOut=0 for BIT_HALF cycles, then clkOut=1 for BIT_HALF cycles.
  - One word = 2*BIT_HALF*WORD_W cycles.
  - Back-to-back words have no gap.
  - clkOut=0 and dataOut=0 when idle.
  - clkOut is a registered output, never a gated or forwarded clk.
- busy rises the cycle after load and falls after the last high half of the final bit.
- Simultaneous events:
  - A threshold command and the frame start in the same cycle: the command is sent before the header.
  - localTransferInput==01 outside IDLE is ignored.

Decomposition:
- Shared package scanner_pkg:
  - state encodings.
  - CMD_READY=2, CMD_START=3, CMD_FULL=4, CMD_DATA=7.
  - peer codes PEER_START=2'b01, PEER_HALF=2'b10.
- Sub-module serial_word_tx (WORD_W, BIT_HALF):
  - Inputs: load, word. Outputs: busy, done pulse, clkOut, dataOut.
  - The top-level FSM, fill counter and command queue sit in scanner_link_tx.

Test Plan:
- Reset: assert rst mid-word -> clkOut=0, dataOut=0, busy=0, fillLevel=0, stateOut=0 within the same cycle (async).
- Fill and commands (defaults, start code 01, readyForTransferIn=0):
  - Fill increments every 8 cycles.
  - Words 0x02, 0x03, 0x04 are emitted exactly once each, MSB first, 16 cycles per word.
  - Ends in STANDBY with fillLevel=10.
- Grant from STANDBY: raise readyForTransferIn -> frame 0x07, 0x0A, then 0x00..0x09 (12 words, 192 cycles) -> IDLE, fillLevel=0.
- Peer-half abort: drive 10 during the 3rd payload word -> that word completes, no further clkOut edges, DRAIN then IDLE.
- Peer-half from STANDBY: readyForTransferIn=0, localTransferInput=10 -> TRANSFER and the header 0x07 starts.
- Parameter sweep: WORD_W=16, BIT_HALF=3, DEPTH=20 -> 96 cycles per word; the count word is 0x0014.
